dffram_bist: RTL and testbench

Memory built-in self-test controller that acts as the initiator on a single DFFRAM port (EN0/WE0/A0/Di0/Do0). On a start pulse it runs a March C- sequence followed by a byte-lane write-mask check over every word, compares every read against the expected value, and reports pass/fail with the first failing address and data. It sits beside each DFFRAM macro and is muxed onto the RAM port by the integrator during test mode.

---
 rtl/dffram_bist.sv | 149 ++++++++++++++
 tb/tb_dffram_bist.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dffram_bist.sv
// March C- plus byte-lane write-mask BIST initiator for a single DFFRAM port.
// Drives EN0/WE0/A0/Di0 and compares Do0 RD_LAT edges after each read issue.
module dffram_bist #(
    parameter  int WSIZE  = 4,
    parameter  int BANKS  = 4,
    parameter  int RD_LAT = 1,
    localparam int AWIDTH = $clog2(BANKS) + 4,
    localparam int DW     = WSIZE * 8
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [DW-1:0]     fail_exp,
    output logic [DW-1:0]     fail_got,
    output logic              EN0,
    output logic [WSIZE-1:0]  WE0,
    output logic [AWIDTH-1:0] A0,
    output logic [DW-1:0]     Di0,
    input  logic [DW-1:0]     Do0
);
    localparam int LW = $clog2(RD_LAT + 2);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] FAIL_HOLD = 2'd2;
    localparam logic [1:0] PASS_HOLD = 2'd3;

    function automatic logic [DW-1:0] lane_alt(input logic [7:0] ev, input logic [7:0] od);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < WSIZE; i++) r[8*i +: 8] = (i % 2 == 0) ? ev : od;
        return r;
    endfunction

    function automatic logic [WSIZE-1:0] even_mask();
        logic [WSIZE-1:0] m;
        m = '0;
        for (int i = 0; i < WSIZE; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [DW-1:0]    PAT_Z  = '0;
    localparam logic [DW-1:0]    PAT_O  = '1;
    localparam logic [DW-1:0]    PAT_A  = {WSIZE{8'hA5}};
    localparam logic [DW-1:0]    PAT_B  = {WSIZE{8'h5A}};
    localparam logic [DW-1:0]    PAT_C  = lane_alt(8'h5A, 8'hA5);
    localparam logic [WSIZE-1:0] MASK_M = even_mask();

    logic [1:0]        state;
    logic [2:0]        elem;
    logic [AWIDTH-1:0] addr;
    logic              opi;
    logic [LW-1:0]     lat;

    logic              down, two_ops, cur_rd, last_op, word_end, next_down, run;
    logic [DW-1:0]     wdata, rexp;
    logic [WSIZE-1:0]  wmask;

    // Element table: op order, direction, write pattern/mask and read expectation.
    always_comb begin
        down    = (elem == 3'd3) || (elem == 3'd4);
        two_ops = (elem != 3'd0) && (elem != 3'd5) && (elem != 3'd6);
        cur_rd  = (opi == 1'b0) ? ((elem >= 3'd1) && (elem <= 3'd5)) : (elem == 3'd7);
        wmask   = '1;
        wdata   = PAT_Z;
        rexp    = PAT_Z;
        case (elem)
            3'd1:    begin rexp = PAT_Z; wdata = PAT_O; end
            3'd2:    begin rexp = PAT_O; wdata = PAT_Z; end
            3'd3:    begin rexp = PAT_Z; wdata = PAT_O; end
            3'd4:    begin rexp = PAT_O; wdata = PAT_Z; end
            3'd6:    wdata = PAT_A;
            3'd7:    begin wdata = PAT_B; wmask = MASK_M; rexp = PAT_C; end
            default: ;
        endcase
        last_op   = two_ops ? opi : 1'b1;
        word_end  = down ? (addr == '0) : (addr == '1);
        next_down = (elem == 3'd2) || (elem == 3'd3);
    end

    assign run  = (state == RUN);
    assign busy = (state != IDLE);
    assign done = (state == FAIL_HOLD) || (state == PASS_HOLD);
    // Port drive is decoded from registered state so reset drops it asynchronously.
    assign EN0  = run && (!cur_rd || lat == '0);
    assign WE0  = (run && !cur_rd) ? wmask : '0;
    assign A0   = run ? addr : '0;
    assign Di0  = (run && !cur_rd) ? wdata : '0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            elem      <= '0;
            addr      <= '0;
            opi       <= 1'b0;
            lat       <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    elem      <= '0;
                    addr      <= '0;
                    opi       <= 1'b0;
                    lat       <= '0;
                    pass      <= 1'b0;
                    fail_addr <= '0;
                    fail_exp  <= '0;
                    fail_got  <= '0;
                end
                RUN: begin
                    if (cur_rd && lat != LW'(RD_LAT)) begin
                        lat <= lat + 1'b1;
                    end else if (cur_rd && (Do0 !== rexp)) begin
                        fail_addr <= addr;
                        fail_exp  <= rexp;
                        fail_got  <= Do0;
                        pass      <= 1'b0;
                        state     <= FAIL_HOLD;
                    end else begin
                        lat <= '0;
                        if (!last_op) begin
                            opi <= 1'b1;
                        end else begin
                            opi <= 1'b0;
                            if (!word_end) begin
                                addr <= down ? addr - 1'b1 : addr + 1'b1;
                            end else if (elem == 3'd7) begin
                                pass  <= 1'b1;
                                state <= PASS_HOLD;
                            end else begin
                                elem <= elem + 1'b1;
                                addr <= next_down ? '1 : '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dffram_bist.sv
// Directed bench for dffram_bist: behavioural RAM with injectable faults, hand-computed latencies.
module tb_dffram_bist;
    localparam int N = 64;

    logic        CLK = 1'b0;
    logic        RESETn, start;
    logic        busy, done, pass, EN0;
    logic [5:0]  fail_addr, A0;
    logic [31:0] fail_exp, fail_got, Di0;
    logic [31:0] Do0 = '0;
    logic [3:0]  WE0;

    int n_chk = 0, n_err = 0;
    int cyc = 0, t0 = 0, fault = 0, lat = 0;
    logic [31:0] mem [0:N-1];
    logic [31:0] rd_word;

    dffram_bist dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0)
    );

    always #5 CLK = ~CLK;

    // Fault 1: Do0[0] stuck high at 'h12. Fault 2: WE0[2] lost on partial-mask writes at 'h05.
    // Fault 3: Do0[31] flipped on reads of 'h3F captured during the down elements E3/E4.
    always_comb begin
        rd_word = mem[A0];
        if (fault == 1 && A0 == 6'h12) rd_word[0] = 1'b1;
        if (fault == 3 && A0 == 6'h3F && (cyc - t0) > 7*N && (cyc - t0) <= 13*N)
            rd_word[31] = ~rd_word[31];
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (EN0) begin
            if (WE0 == 4'b0) Do0 <= rd_word;
            else for (int i = 0; i < 4; i++)
                if (WE0[i] && !(fault == 2 && A0 == 6'h05 && i == 2 && WE0 != 4'hF))
                    mem[A0][8*i +: 8] <= Di0[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic kick();
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); t0 = cyc;
        @(negedge CLK); start = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (done !== 1'b1 && l < 3000) begin @(negedge CLK); l++; end
    endtask

    task automatic run_one(input string tag, input int elat, input logic epass,
                           input logic [5:0] eaddr, input logic [31:0] eexp, input logic [31:0] egot);
        logic en_seen;
        kick();
        chk({tag, " busy@start"}, busy, 1);
        chk({tag, " addr clr"}, fail_addr, 0);
        chk({tag, " got clr"}, fail_got, 0);
        wait_done(lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " pass"}, pass, epass);
        chk({tag, " fail_addr"}, fail_addr, eaddr);
        chk({tag, " fail_exp"}, fail_exp, eexp);
        chk({tag, " fail_got"}, fail_got, egot);
        en_seen = EN0;
        @(negedge CLK);
        chk({tag, " done 1cyc"}, done, 0);
        chk({tag, " busy off"}, busy, 0);
        for (int i = 0; i < 4; i++) begin en_seen |= EN0; @(negedge CLK); end
        chk({tag, " EN0 quiet"}, en_seen, 0);
    endtask

    initial begin
        logic any_done;
        RESETn = 1'b0; start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst EN0", EN0, 0);
        chk("rst WE0", WE0, 0);
        chk("rst A0", A0, 0);
        chk("rst Di0", Di0, 0);
        chk("rst fail_exp", fail_exp, 0);
        RESETn = 1'b1;

        fault = 0; run_one("good", 19*N, 1'b1, 6'h00, 32'h0, 32'h0);
        // E1 word 'h12 compare edge: N + 3*18 + 2
        fault = 1; run_one("stuck", N + 3*18 + 2, 1'b0, 6'h12, 32'h00000000, 32'h00000001);
        // E7 word 5 compare edge: 16N + 3*5 + 3
        fault = 2; run_one("lane", 16*N + 3*5 + 3, 1'b0, 6'h05, 32'hA55AA55A, 32'hA5A5A55A);
        // First E3 read (addr N-1) compare edge: 7N + 2
        fault = 3; run_one("down", 7*N + 2, 1'b0, 6'h3F, 32'h00000000, 32'h80000000);
        fault = 0;

        // Reset in cycle 500 (E3 read issue), checked before any clock edge.
        kick();
        repeat (499) @(negedge CLK);
        chk("midrst EN0 before", EN0, 1);
        #1 RESETn = 1'b0;
        #1;
        chk("midrst EN0", EN0, 0);
        chk("midrst WE0", WE0, 0);
        chk("midrst busy", busy, 0);
        any_done = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge CLK); any_done |= done; end
        chk("midrst no done", any_done, 0);
        RESETn = 1'b1;
        run_one("relaunch", 19*N, 1'b1, 6'h00, 32'h0, 32'h0);

        // start held high: one run, one IDLE cycle, then exactly one relaunch.
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); t0 = cyc;
        @(negedge CLK);
        wait_done(lat);
        chk("held latency", lat, 19*N);
        chk("held pass", pass, 1);
        @(negedge CLK);
        chk("held idle gap", busy, 0);
        @(posedge CLK); t0 = cyc;
        @(negedge CLK); start = 1'b0;
        chk("held relaunch", busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge CLK); lat++;
            start = (lat == 300);
        end
        start = 1'b0;
        chk("pulse latency", lat, 19*N);
        chk("pulse pass", pass, 1);
        @(negedge CLK);
        @(negedge CLK);
        chk("no extra run", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
